accel_spi_responder: RTL and testbench
======================================

// Module: accel_spi_responder
// PURPOSE
//  SPI slave (mode 3) emulating the accelerometer's register interface.
//  Pairs with spi_control as the other end of the GSENSOR SPI link, so the board and sim run without the sensor.
//  Axis data comes from ports (switches or bench), not a MEMS core.
// PARAMETERS
//  DEVID        8'hE5  value returned at address 0x00
//  SYNC_STAGES  2      synchronizer depth on spi_sclk/spi_csn/spi_sdi (>=2)
// PORTS
//  clk           in   1   system clock; must be >= 8x spi_sclk (25 MHz vs 2 MHz)
//  reset_n       in   1   asynchronous, active-low reset
//  spi_sclk      in   1   SPI clock from master, idles high
//  spi_csn       in   1   chip select, active low
//  spi_sdi       in   1   master-out data
//  spi_sdo       out  1   slave-out data, valid only while spi_sdo_oe=1
//  spi_sdo_oe    out  1   tristate enable for spi_sdo
//  data_x/y/z    in   16  signed axis samples, two's complement
//  sample_valid  in   1   1-clk strobe: new sample present on data_x/y/z
//  int1          out  1   data-ready interrupt, active high
// BEHAVIOUR
//  Reset values: spi_sdo=1, spi_sdo_oe=0, int1=0, state=IDLE.
//  Reset values (regs): BW_RATE=0x0A, POWER_CTL=DATA_FORMAT=INT_ENABLE=0x00, snapshot=0.
//  Inputs pass through SYNC_STAGES flops; csn synchronizer flops reset to 0, so csn held low across reset release is no start.
//  Edges are detected on synced sclk: sample spi_sdi on rise; drive spi_sdo on fall.
//  FSM: IDLE -> CMD on synced csn 1->0, bit_cnt=0, snapshot<=data_x/y/z (coherent multibyte read).
//  CMD: 8 rises shift in {rw,mb,addr[5:0]} MSB first; then -> RD if rw=1, else -> WR.
//  RD: spi_sdo_oe=1; read byte loaded at the 8th CMD rise.
//  RD: MSB driven on the following sclk fall, next bit on each later fall.
//  RD: after 8 bits, addr+=mb (6-bit wrap 0x3F->0x00), reload, continue.
//  WR: 8 rises shift a byte; on the 8th rise write reg[addr], then addr+=mb.
//  Any state: synced csn 0->1 -> IDLE, spi_sdo_oe=0 within 1 clk.
//  Any state: a partial byte is discarded; a partial write performs no write.
//  spi_sdo update latency: <= SYNC_STAGES+2 clk after the physical sclk fall.
//  Map: 0x00 DEVID (RO); 0x2C BW_RATE, 0x2D POWER_CTL, 0x31 DATA_FORMAT are RW 8-bit.
//  Map: 0x32..0x37 = snapshot X lo, X hi, Y lo, Y hi, Z lo, Z hi (RO).
//  Map: any other address reads 0x00; writes to it and to RO addresses are ignored.
//  Address 0x00 is not writable; bit_cnt is 3 bits and wraps per byte.
// CONFIGURATION
//  ACCEL_INT_EN defined: 0x2E INT_ENABLE is RW; 0x30 INT_SOURCE is RO, bit7=DATA_READY.
//  ACCEL_INT_EN defined: DATA_READY is set by sample_valid.
//  ACCEL_INT_EN defined: DATA_READY is cleared at csn rise if any of 0x32..0x37 was fully read in that transaction.
//  ACCEL_INT_EN defined: if sample_valid coincides with that clear, set wins.
//  ACCEL_INT_EN defined: int1 = DATA_READY & INT_ENABLE[7], registered.
//  ACCEL_INT_EN undefined: 0x2E/0x30 read 0x00, writes ignored, int1 tied 0.
// TESTING
//  1 DEVID: csn low, cmd 0x80, 8 clocks -> sdo returns 0xE5; sdo_oe falls after csn high.
//  2 RW reg: write 0x2D=0x08 (cmd 0x2D), then read cmd 0xAD -> returns 0x08.
//  2 RW reg: write 0x00=0x55 -> a later read of 0x00 still returns 0xE5.
//  3 Multibyte: inputs x=0x1234, y=0xFF9C, z=0x0100; read cmd 0xF2 -> 34 12 9C FF 00 01.
//  3 Multibyte: x changed to 0xAAAA mid-burst -> bytes unchanged.
//  4 Abort: cmd 0x31 + 5 data bits, csn high -> DATA_FORMAT stays 0x00.
//  4 Abort: a next clean transaction succeeds.
//  5 ACCEL_INT_EN: write 0x2E=0x80, pulse sample_valid -> int1=1, 0x30 reads 0x80.
//  5 ACCEL_INT_EN: read 0x32 then csn high -> int1=0; macro undefined -> int1 stays 0.
//  6 Reset mid-read of 0xF2 (csn held low): sdo_oe=0, no response.
//  6 After csn high then low, DEVID read returns 0xE5.

Source files
------------

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: mode-3 SPI slave emulating the accelerometer register map, axis data taken from ports.
// Define ACCEL_INT_EN to add INT_ENABLE/INT_SOURCE and the DATA_READY interrupt on int1.
module accel_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic [15:0] data_x,
    input  logic [15:0] data_y,
    input  logic [15:0] data_z,
    input  logic        sample_valid,
    output logic        int1
);
    typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, csn_sync_q, csn_sync_d, sdi_sync_q, sdi_sync_d;
    logic sclk_prev_q, sclk_prev_d, csn_prev_q, csn_prev_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [5:0] addr_q, addr_d;
    logic mb_q, mb_d;
    logic [7:0] tx_q, tx_d;
    logic sdo_q, sdo_d;
    logic [47:0] snap_q, snap_d;
    logic [7:0] bw_q, bw_d, pwr_q, pwr_d, fmt_q, fmt_d;
    logic sclk_s, csn_s, sdi_s, sclk_rise, sclk_fall, csn_rise, csn_fall, byte_done, wr_en;
    logic [7:0] cmd_byte, rd_byte;
    logic [5:0] addr_inc, rd_addr;
`ifdef ACCEL_INT_EN
    logic [7:0] ien_q, ien_d;
    logic dr_q, dr_d, int1_q, int1_d, axis_rd_q, axis_rd_d;
`endif

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        csn_s       = csn_sync_q[SYNC_STAGES-1];
        sdi_s       = sdi_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        csn_prev_d  = csn_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        csn_rise    = csn_s & ~csn_prev_q;
        csn_fall    = ~csn_s & csn_prev_q;
        byte_done   = sclk_rise & (bit_cnt_q == 3'd7);
        cmd_byte    = {shift_q, sdi_s};
        addr_inc    = addr_q + {5'd0, mb_q};
        rd_addr     = (state_q == CMD) ? cmd_byte[5:0] : addr_inc;
        wr_en       = (state_q == WR) & byte_done & ~csn_rise & ~csn_fall;
    end

    // Read mux serves both the first byte (addressed by the command) and burst reloads
    always_comb begin
        rd_byte = 8'h00;
        case (rd_addr)
            6'h00: rd_byte = DEVID;
            6'h2C: rd_byte = bw_q;
            6'h2D: rd_byte = pwr_q;
            6'h31: rd_byte = fmt_q;
            6'h32: rd_byte = snap_q[7:0];
            6'h33: rd_byte = snap_q[15:8];
            6'h34: rd_byte = snap_q[23:16];
            6'h35: rd_byte = snap_q[31:24];
            6'h36: rd_byte = snap_q[39:32];
            6'h37: rd_byte = snap_q[47:40];
`ifdef ACCEL_INT_EN
            6'h2E: rd_byte = ien_q;
            6'h30: rd_byte = {dr_q, 7'd0};
`endif
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        mb_d      = mb_q;
        tx_d      = tx_q;
        sdo_d     = sdo_q;
        snap_d    = snap_q;
        if (csn_rise) begin
            state_d = IDLE;
        end else if (csn_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
            sdo_d     = 1'b1;
            snap_d    = {data_z, data_y, data_x};
        end else begin
            case (state_q)
                CMD: if (sclk_rise) begin
                    shift_d   = cmd_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        addr_d  = cmd_byte[5:0];
                        mb_d    = cmd_byte[6];
                        tx_d    = rd_byte;
                        state_d = cmd_byte[7] ? RD : WR;
                    end
                end
                RD: begin
                    if (sclk_fall) begin
                        sdo_d = tx_q[7];
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_done) begin
                            addr_d = addr_inc;
                            tx_d   = rd_byte;
                        end
                    end
                end
                WR: if (sclk_rise) begin
                    shift_d   = cmd_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) addr_d = addr_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bw_d  = (wr_en && addr_q == 6'h2C) ? cmd_byte : bw_q;
        pwr_d = (wr_en && addr_q == 6'h2D) ? cmd_byte : pwr_q;
        fmt_d = (wr_en && addr_q == 6'h31) ? cmd_byte : fmt_q;
    end

`ifdef ACCEL_INT_EN
    // A sample arriving in the same cycle as the read-clear keeps DATA_READY set
    always_comb begin
        ien_d     = (wr_en && addr_q == 6'h2E) ? cmd_byte : ien_q;
        axis_rd_d = csn_fall ? 1'b0
                  : (state_q == RD && byte_done && addr_q >= 6'h32 && addr_q <= 6'h37) ? 1'b1
                  : axis_rd_q;
        dr_d      = sample_valid | (dr_q & ~(csn_rise & axis_rd_q));
        int1_d    = dr_q & ien_q[7];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ien_q     <= 8'h00;
            axis_rd_q <= 1'b0;
            dr_q      <= 1'b0;
            int1_q    <= 1'b0;
        end else begin
            ien_q     <= ien_d;
            axis_rd_q <= axis_rd_d;
            dr_q      <= dr_d;
            int1_q    <= int1_d;
        end
    end

    assign int1 = int1_q;
`else
    logic unused_sample_valid;
    assign unused_sample_valid = sample_valid;
    assign int1 = 1'b0;
`endif

    // csn synchronizer resets low so a csn already low at reset release is not a start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sclk_sync_q <= '1;
            csn_sync_q  <= '0;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b1;
            csn_prev_q  <= 1'b0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            addr_q      <= 6'd0;
            mb_q        <= 1'b0;
            tx_q        <= 8'h00;
            sdo_q       <= 1'b1;
            snap_q      <= 48'd0;
            bw_q        <= 8'h0A;
            pwr_q       <= 8'h00;
            fmt_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            csn_sync_q  <= csn_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            csn_prev_q  <= csn_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            mb_q        <= mb_d;
            tx_q        <= tx_d;
            sdo_q       <= sdo_d;
            snap_q      <= snap_d;
            bw_q        <= bw_d;
            pwr_q       <= pwr_d;
            fmt_q       <= fmt_d;
        end
    end

    assign spi_sdo    = sdo_q;
    assign spi_sdo_oe = (state_q == RD);
endmodule

// File: tb/tb_accel_spi_responder.sv
// tb_accel_spi_responder: directed SPI master transactions against accel_spi_responder.
module tb_accel_spi_responder;
    logic clk = 1'b0, reset_n = 1'b1;
    logic spi_sclk = 1'b1, spi_csn = 1'b1, spi_sdi = 1'b0;
    logic spi_sdo, spi_sdo_oe, int1;
    logic [15:0] data_x = 16'h0, data_y = 16'h0, data_z = 16'h0;
    logic sample_valid = 1'b0;
    logic oe_seen;
    int n_cmp = 0, n_bad = 0;

    accel_spi_responder dut (
        .clk(clk), .reset_n(reset_n), .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .data_x(data_x), .data_y(data_y),
        .data_z(data_z), .sample_valid(sample_valid), .int1(int1)
    );

    always #5 clk = ~clk;

    task automatic spi_byte(input logic [7:0] o, output logic [7:0] i);
        for (int k = 7; k >= 0; k--) begin
            spi_sclk = 1'b0;
            spi_sdi  = o[k];
            #50;
            spi_sclk = 1'b1;
            i[k]     = spi_sdo;
            #50;
        end
    endtask

    task automatic xfer(input logic [7:0] cmd, input int n, input logic [47:0] wd, output logic [47:0] rd);
        logic [7:0] b;
        rd = '0;
        spi_csn = 1'b0;
        #50;
        spi_byte(cmd, b);
        for (int k = 0; k < n; k++) begin
            spi_byte(wd[k*8+:8], b);
            rd[k*8+:8] = b;
        end
        #50;
        oe_seen = spi_sdo_oe;
        spi_csn = 1'b1;
        #100;
    endtask

    task automatic test_reset;
        #10 reset_n = 1'b0;
        #20;
        n_cmp++; if (spi_sdo !== 1'b1) begin n_bad++; $display("FAIL reset_sdo: got %b expected 1", spi_sdo); end
        n_cmp++; if (spi_sdo_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b expected 0", spi_sdo_oe); end
        n_cmp++; if (int1 !== 1'b0) begin n_bad++; $display("FAIL reset_int1: got %b expected 0", int1); end
        reset_n = 1'b1;
        #100;
    endtask

    task automatic test_devid;
        logic [47:0] r;
        xfer(8'h80, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'hE5) begin n_bad++; $display("FAIL devid: got %h expected e5", r[7:0]); end
        n_cmp++; if (oe_seen !== 1'b1) begin n_bad++; $display("FAIL devid_oe_active: got %b expected 1", oe_seen); end
        n_cmp++; if (spi_sdo_oe !== 1'b0) begin n_bad++; $display("FAIL devid_oe_release: got %b expected 0", spi_sdo_oe); end
    endtask

    task automatic test_rw_reg;
        logic [47:0] r;
        xfer(8'hAC, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'h0A) begin n_bad++; $display("FAIL bw_rate_reset: got %h expected 0a", r[7:0]); end
        xfer(8'h2D, 1, 48'h08, r);
        xfer(8'hAD, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'h08) begin n_bad++; $display("FAIL power_ctl: got %h expected 08", r[7:0]); end
        xfer(8'h00, 1, 48'h55, r);
        xfer(8'h80, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'hE5) begin n_bad++; $display("FAIL devid_ro: got %h expected e5", r[7:0]); end
        xfer(8'h2A, 1, 48'h77, r);
        xfer(8'hAA, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'h00) begin n_bad++; $display("FAIL unmapped: got %h expected 00", r[7:0]); end
    endtask

    task automatic test_multibyte;
        logic [47:0] r;
        data_x = 16'h1234; data_y = 16'hFF9C; data_z = 16'h0100;
        xfer(8'hF2, 6, 48'h0, r);
        n_cmp++; if (r !== 48'h0100FF9C1234) begin n_bad++; $display("FAIL burst: got %h expected 0100ff9c1234", r); end
        xfer(8'hB2, 2, 48'h0, r);
        n_cmp++; if (r[15:0] !== 16'h3434) begin n_bad++; $display("FAIL no_increment: got %h expected 3434", r[15:0]); end
        xfer(8'hFF, 2, 48'h0, r);
        n_cmp++; if (r[15:0] !== 16'hE500) begin n_bad++; $display("FAIL addr_wrap: got %h expected e500", r[15:0]); end
        fork
            xfer(8'hF2, 6, 48'h0, r);
            begin #1500 data_x = 16'hAAAA; end
        join
        n_cmp++; if (r !== 48'h0100FF9C1234) begin n_bad++; $display("FAIL coherent: got %h expected 0100ff9c1234", r); end
        xfer(8'hF2, 2, 48'h0, r);
        n_cmp++; if (r[15:0] !== 16'hAAAA) begin n_bad++; $display("FAIL new_snapshot: got %h expected aaaa", r[15:0]); end
    endtask

    task automatic test_abort;
        logic [47:0] r;
        logic [7:0] b;
        spi_csn = 1'b0;
        #50;
        spi_byte(8'h31, b);
        for (int k = 0; k < 5; k++) begin
            spi_sclk = 1'b0; spi_sdi = 1'b1; #50;
            spi_sclk = 1'b1; #50;
        end
        #50 spi_csn = 1'b1;
        #100;
        xfer(8'hB1, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'h00) begin n_bad++; $display("FAIL abort_no_write: got %h expected 00", r[7:0]); end
        xfer(8'h31, 1, 48'h0B, r);
        xfer(8'hB1, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'h0B) begin n_bad++; $display("FAIL after_abort: got %h expected 0b", r[7:0]); end
        xfer(8'hAE, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'h00) begin n_bad++; $display("FAIL int_enable_reset: got %h expected 00", r[7:0]); end
    endtask

    task automatic test_int;
        logic [47:0] r;
        xfer(8'h2E, 1, 48'h80, r);
        sample_valid = 1'b1; #10 sample_valid = 1'b0;
        #30;
`ifdef ACCEL_INT_EN
        n_cmp++; if (int1 !== 1'b1) begin n_bad++; $display("FAIL int1_set: got %b expected 1", int1); end
        xfer(8'hB0, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'h80) begin n_bad++; $display("FAIL int_source: got %h expected 80", r[7:0]); end
        n_cmp++; if (int1 !== 1'b1) begin n_bad++; $display("FAIL int1_kept: got %b expected 1", int1); end
        xfer(8'hB2, 1, 48'h0, r);
        n_cmp++; if (int1 !== 1'b0) begin n_bad++; $display("FAIL int1_clear: got %b expected 0", int1); end
`else
        n_cmp++; if (int1 !== 1'b0) begin n_bad++; $display("FAIL int1_tied: got %b expected 0", int1); end
        xfer(8'hAE, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'h00) begin n_bad++; $display("FAIL int_enable_absent: got %h expected 00", r[7:0]); end
        xfer(8'hB0, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'h00) begin n_bad++; $display("FAIL int_source_absent: got %h expected 00", r[7:0]); end
        xfer(8'hB2, 1, 48'h0, r);
        n_cmp++; if (int1 !== 1'b0) begin n_bad++; $display("FAIL int1_stays: got %b expected 0", int1); end
`endif
    endtask

    task automatic test_reset_mid_read;
        logic [47:0] r;
        logic [7:0] b;
        spi_csn = 1'b0;
        #50;
        spi_byte(8'hF2, b);
        for (int k = 0; k < 3; k++) begin
            spi_sclk = 1'b0; #50;
            spi_sclk = 1'b1; #50;
        end
        reset_n = 1'b0;
        #20;
        n_cmp++; if (spi_sdo_oe !== 1'b0) begin n_bad++; $display("FAIL midreset_oe: got %b expected 0", spi_sdo_oe); end
        #20 reset_n = 1'b1;
        #20;
        spi_byte(8'h00, b);
        n_cmp++; if (spi_sdo_oe !== 1'b0) begin n_bad++; $display("FAIL midreset_no_start: got %b expected 0", spi_sdo_oe); end
        n_cmp++; if (b !== 8'hFF) begin n_bad++; $display("FAIL midreset_sdo: got %h expected ff", b); end
        spi_csn = 1'b1;
        #100;
        xfer(8'h80, 1, 48'h0, r);
        n_cmp++; if (r[7:0] !== 8'hE5) begin n_bad++; $display("FAIL devid_after_reset: got %h expected e5", r[7:0]); end
    endtask

    initial begin
        test_reset;
        test_devid;
        test_rw_reg;
        test_multibyte;
        test_abort;
        test_int;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
